pc_ctrl: RTL and testbench

- Parametrised program-counter and interrupt-entry unit for the next-generation CPU core.
- Replaces the fixed in-line PC register and single-IRQ handling with configurable address width, configurable vectors and N maskable interrupt channels.
- Adds fixed-priority arbitration, EPC capture, exception return (eret) and a fetch stall.
- Sits between the control decoder and the instruction ROM; its `pc` output drives the ROM address.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/pc_ctrl_if.sv | 53 +++++
 rtl/irq_arb.sv | 65 ++++++
 rtl/pc_ctrl.sv | 145 ++++++++++++++
 tb/tb_pc_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared encodings and constants for the CPU core front end:
//                pc_src select codes, default vectors, interrupt cause width
//                and the handler-state type used by pc_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // pc_src encodings (values 6 and 7 both select the reset vector)
  localparam logic [2:0] PC_SEQ   = 3'd0;
  localparam logic [2:0] PC_BR    = 3'd1;
  localparam logic [2:0] PC_J     = 3'd2;
  localparam logic [2:0] PC_JR    = 3'd3;
  localparam logic [2:0] PC_ILLOP = 3'd4;
  localparam logic [2:0] PC_XADR  = 3'd5;
  localparam logic [2:0] PC_RST   = 3'd6;

  // Default vectors
  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

  // Width of the interrupt cause field (up to 16 channels)
  localparam int CAUSE_W = 4;

  // Handler state: SVC_ACTIVE while an exception/interrupt handler runs
  typedef enum logic {
    SVC_IDLE   = 1'b0,
    SVC_ACTIVE = 1'b1
  } svc_state_e;

  // Index of the lowest set bit; 0 when no bit is set
  function automatic logic [CAUSE_W-1:0] lowest_set(input logic [15:0] v);
    logic [CAUSE_W-1:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = CAUSE_W'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ctrl_if.sv
// ============================================================================
//  Module      : pc_ctrl_if
//  Description : Decoder/ROM-side bundle of pc_ctrl.
//                master : control decoder side (drives redirect / irq inputs)
//                slave  : pc_ctrl side (drives pc, epc and interrupt status)
//  Signals     : stall, pc_src[2:0], br_taken, imm16[15:0], target26[25:0],
//                jr_addr[ADDR_W], eret, irq[NUM_IRQ], mask_we,
//                mask_wdata[NUM_IRQ]  -> pc_ctrl
//                pc, pc_plus4, epc [ADDR_W], irq_take, irq_cause[4],
//                irq_pending[NUM_IRQ], in_service  <- pc_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int NUM_IRQ = 4
);

  logic                        stall;
  logic [2:0]                  pc_src;
  logic                        br_taken;
  logic [15:0]                 imm16;
  logic [25:0]                 target26;
  logic [ADDR_W-1:0]           jr_addr;
  logic                        eret;
  logic [NUM_IRQ-1:0]          irq;
  logic                        mask_we;
  logic [NUM_IRQ-1:0]          mask_wdata;

  logic [ADDR_W-1:0]           pc;
  logic [ADDR_W-1:0]           pc_plus4;
  logic [ADDR_W-1:0]           epc;
  logic                        irq_take;
  logic [cpu_pkg::CAUSE_W-1:0] irq_cause;
  logic [NUM_IRQ-1:0]          irq_pending;
  logic                        in_service;

  modport master (
    output stall, pc_src, br_taken, imm16, target26, jr_addr, eret,
           irq, mask_we, mask_wdata,
    input  pc, pc_plus4, epc, irq_take, irq_cause, irq_pending, in_service
  );

  modport slave (
    input  stall, pc_src, br_taken, imm16, target26, jr_addr, eret,
           irq, mask_we, mask_wdata,
    output pc, pc_plus4, epc, irq_take, irq_cause, irq_pending, in_service
  );

endinterface

`default_nettype wire

// File: rtl/irq_arb.sv
// ============================================================================
//  Module      : irq_arb
//  Description : Interrupt edge detect, pending latch, enable mask and
//                fixed-priority (lowest index wins) encoder.
//  Ports       : clk, reset        - clock, async active-high reset
//                i_irq             - level requests, synchronous to clk
//                i_mask_we/wdata   - enable-mask write
//                i_take            - the current winner is being entered
//                o_any_req         - some pending channel is enabled
//                o_cause           - index of the winning channel
//                o_pending         - pending bits
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_arb
  import cpu_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic [NUM_IRQ-1:0] i_irq,
  input  wire logic               i_mask_we,
  input  wire logic [NUM_IRQ-1:0] i_mask_wdata,
  input  wire logic               i_take,
  output logic                    o_any_req,
  output logic [CAUSE_W-1:0]      o_cause,
  output logic [NUM_IRQ-1:0]      o_pending
);

  logic [NUM_IRQ-1:0] r_irq_d;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_mask;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_act;
  logic [NUM_IRQ-1:0] w_clr;
  logic [CAUSE_W-1:0] w_cause;

  assign w_rise  = i_irq & ~r_irq_d;
  assign w_act   = r_pend & r_mask;
  assign w_cause = lowest_set(16'(w_act));
  assign w_clr   = i_take ? (NUM_IRQ'(1) << w_cause) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_d <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
    end else begin
      r_irq_d <= i_irq;
      // OR-ing the new edges after the clear lets a fresh edge win
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (i_mask_we) r_mask <= i_mask_wdata;
    end
  end

  assign o_any_req = |w_act;
  assign o_cause   = w_cause;
  assign o_pending = r_pend;

endmodule

`default_nettype wire

// File: rtl/pc_ctrl.sv
// ============================================================================
//  Module      : pc_ctrl
//  Description : Program counter and interrupt-entry unit. Holds PC, EPC and
//                the handler state, selects the next PC with priority
//                exception > eret > interrupt > pc_src, and hosts irq_arb.
//                Requires ADDR_W >= 29 (jump keeps pc_plus4[ADDR_W-1:28]).
//  Ports       : clk, reset  - clock, async active-high reset
//                bus         - pc_ctrl_if.slave (decoder inputs, pc/epc and
//                              interrupt status outputs)
//  Build macro : IRQ_VECTORED_EN - when defined, interrupt entry goes to
//                ILLOP_VEC + 16 + 8*cause instead of ILLOP_VEC.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ctrl
  import cpu_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              NUM_IRQ   = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] ILLOP_VEC = ADDR_W'(DEF_ILLOP_VEC),
  parameter logic [ADDR_W-1:0] XADR_VEC  = ADDR_W'(DEF_XADR_VEC)
) (
  input wire logic clk,
  input wire logic reset,
  pc_ctrl_if.slave bus
);

  localparam int MSB = ADDR_W - 1;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_epc;
  svc_state_e         r_state;
  logic               r_irq_take;
  logic [CAUSE_W-1:0] r_irq_cause;

  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [ADDR_W-1:0]  w_epc_nxt;
  svc_state_e         w_state_nxt;
  logic               w_take;

  logic               w_any_req;
  logic [CAUSE_W-1:0] w_cause;

  logic [MSB-1:0]     w_pc_inc;
  logic [ADDR_W-1:0]  w_pc_p4;
  logic [MSB-1:0]     w_br_off;
  logic [MSB-1:0]     w_br_sum;
  logic [ADDR_W-1:0]  w_br_tgt;
  logic [ADDR_W-1:0]  w_j_tgt;
  logic [ADDR_W-1:0]  w_jr_tgt;
  logic [ADDR_W-1:0]  w_irq_vec;
  logic               w_exc;

  // Sequential and branch arithmetic never carries into the kernel bit
  assign w_pc_inc = r_pc[MSB-1:0] + MSB'(4);
  assign w_pc_p4  = {r_pc[MSB], w_pc_inc};
  assign w_br_off = {{(ADDR_W-19){bus.imm16[15]}}, bus.imm16, 2'b00};
  assign w_br_sum = w_pc_p4[MSB-1:0] + w_br_off;
  assign w_br_tgt = {r_pc[MSB], w_br_sum};
  assign w_j_tgt  = {w_pc_p4[MSB:28], bus.target26, 2'b00};
  // User code may not jump into kernel space through a register
  assign w_jr_tgt = r_pc[MSB] ? bus.jr_addr : {1'b0, bus.jr_addr[MSB-1:0]};

`ifdef IRQ_VECTORED_EN
  assign w_irq_vec = ILLOP_VEC + ADDR_W'(16) + (ADDR_W'(w_cause) << 3);
`else
  assign w_irq_vec = ILLOP_VEC;
`endif

  assign w_exc = (bus.pc_src == PC_ILLOP) || (bus.pc_src == PC_XADR);

  always_comb begin
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_state_nxt = r_state;
    w_take      = 1'b0;
    if (!bus.stall) begin
      if (w_exc) begin
        w_pc_nxt    = (bus.pc_src == PC_ILLOP) ? ILLOP_VEC : XADR_VEC;
        w_epc_nxt   = r_pc;
        w_state_nxt = SVC_ACTIVE;
      end else if (bus.eret) begin
        w_pc_nxt    = r_epc;
        w_state_nxt = SVC_IDLE;
      end else if (w_any_req && !r_pc[MSB] && (r_state == SVC_IDLE)) begin
        // EPC holds the interrupted instruction so it is replayed on eret
        w_take      = 1'b1;
        w_pc_nxt    = w_irq_vec;
        w_epc_nxt   = r_pc;
        w_state_nxt = SVC_ACTIVE;
      end else begin
        case (bus.pc_src)
          PC_SEQ:  w_pc_nxt = w_pc_p4;
          PC_BR:   w_pc_nxt = bus.br_taken ? w_br_tgt : w_pc_p4;
          PC_J:    w_pc_nxt = w_j_tgt;
          PC_JR:   w_pc_nxt = w_jr_tgt;
          default: w_pc_nxt = RESET_VEC;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_VEC;
      r_epc       <= '0;
      r_state     <= SVC_IDLE;
      r_irq_take  <= 1'b0;
      r_irq_cause <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_epc      <= w_epc_nxt;
      r_state    <= w_state_nxt;
      r_irq_take <= w_take;
      // Cause is held so the handler can read it after the entry pulse
      if (w_take) r_irq_cause <= w_cause;
    end
  end

  irq_arb #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_arb (
    .clk          (clk),
    .reset        (reset),
    .i_irq        (bus.irq),
    .i_mask_we    (bus.mask_we),
    .i_mask_wdata (bus.mask_wdata),
    .i_take       (w_take),
    .o_any_req    (w_any_req),
    .o_cause      (w_cause),
    .o_pending    (bus.irq_pending)
  );

  assign bus.pc         = r_pc;
  assign bus.pc_plus4   = w_pc_p4;
  assign bus.epc        = r_epc;
  assign bus.irq_take   = r_irq_take;
  assign bus.irq_cause  = r_irq_cause;
  assign bus.in_service = (r_state == SVC_ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_pc_ctrl.sv
// ============================================================================
//  Module      : tb_pc_ctrl
//  Description : Self-checking bench for pc_ctrl: directed scenarios followed
//                by random stimulus, compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_ctrl;

  localparam int AW = 32;
  localparam int NI = 4;

`ifdef IRQ_VECTORED_EN
  localparam logic [31:0] VEC1 = 32'h8000_001C;
  localparam logic [31:0] VEC3 = 32'h8000_002C;
`else
  localparam logic [31:0] VEC1 = 32'h8000_0004;
  localparam logic [31:0] VEC3 = 32'h8000_0004;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_ctrl_if #(.ADDR_W(AW), .NUM_IRQ(NI)) bus ();

  pc_ctrl #(.ADDR_W(AW), .NUM_IRQ(NI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [31:0] m_pc, m_epc;
  logic        m_insvc, m_take;
  logic [3:0]  m_cause, m_mask, m_pend, m_prev;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] plus4(input logic [31:0] p);
    logic [31:0] t;
    t = p + 32'd4;
    return {p[31], t[30:0]};
  endfunction

  function automatic logic [31:0] irq_entry(input int ch);
`ifdef IRQ_VECTORED_EN
    return 32'h8000_0004 + 32'd16 + 32'(ch) * 32'd8;
`else
    return (ch >= 0) ? 32'h8000_0004 : 32'h8000_0004;
`endif
  endfunction

  task automatic m_reset();
    m_pc = 32'h8000_0000; m_epc = '0; m_insvc = 1'b0; m_take = 1'b0;
    m_cause = '0; m_mask = '0; m_pend = '0; m_prev = '0;
  endtask

  // One clock edge of the reference behaviour
  task automatic model_clk();
    logic [31:0] p4, tgt;
    int          win;
    logic        take, exc;
    if (reset) begin
      m_reset();
      return;
    end
    p4  = plus4(m_pc);
    win = -1;
    for (int i = NI - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
    exc  = (bus.pc_src == 3'd4) || (bus.pc_src == 3'd5);
    take = !bus.stall && !exc && !bus.eret && (win >= 0) && !m_pc[31] && !m_insvc;
    if (!bus.stall) begin
      if (exc) begin
        m_epc   = m_pc;
        m_insvc = 1'b1;
        m_pc    = (bus.pc_src == 3'd4) ? 32'h8000_0004 : 32'h8000_0008;
      end else if (bus.eret) begin
        m_pc    = m_epc;
        m_insvc = 1'b0;
      end else if (take) begin
        m_epc   = m_pc;
        m_insvc = 1'b1;
        m_pc    = irq_entry(win);
      end else begin
        case (bus.pc_src)
          3'd0: m_pc = p4;
          3'd1: begin
            if (bus.br_taken) begin
              tgt     = p4 + 32'($signed(bus.imm16)) * 32'd4;
              tgt[31] = m_pc[31];
              m_pc    = tgt;
            end else begin
              m_pc = p4;
            end
          end
          3'd2: m_pc = {p4[31:28], bus.target26, 2'b00};
          3'd3: m_pc = m_pc[31] ? bus.jr_addr : (bus.jr_addr & 32'h7FFF_FFFF);
          default: m_pc = 32'h8000_0000;
        endcase
      end
    end
    if (take) m_pend[win] = 1'b0;
    m_pend = m_pend | (bus.irq & ~m_prev);
    m_prev = bus.irq;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    m_take = take;
    if (take) m_cause = 4'(win);
  endtask

  task automatic compare_all();
    check_val("pc",          bus.pc,          m_pc);
    check_val("pc_plus4",    bus.pc_plus4,    plus4(m_pc));
    check_val("epc",         bus.epc,         m_epc);
    check_val("irq_take",    bus.irq_take,    m_take);
    check_val("irq_cause",   bus.irq_cause,   m_cause);
    check_val("irq_pending", bus.irq_pending, m_pend);
    check_val("in_service",  bus.in_service,  m_insvc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.pc_src = 3'd0; bus.br_taken = 1'b0; bus.imm16 = '0;
    bus.target26 = '0; bus.jr_addr = '0; bus.eret = 1'b0;
    bus.mask_we = 1'b0; bus.mask_wdata = '0;
  endtask

  task automatic jr_to(input logic [31:0] a);
    idle(); bus.pc_src = 3'd3; bus.jr_addr = a;
  endtask

  initial begin
    int r;
    m_reset();
    idle();
    bus.irq = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check_val("rst_pc", bus.pc, 32'h8000_0000);
    reset = 1'b0;

    // Sequential fetch from the reset vector
    tick(); check_val("seq1", bus.pc, 32'h8000_0004);
    tick(); check_val("seq2", bus.pc, 32'h8000_0008);
    check_val("p4_kbit", bus.pc_plus4, 32'h8000_000C);

    // Branch taken / not taken
    jr_to(32'h0000_0100); tick(); check_val("jr_k_0100", bus.pc, 32'h0000_0100);
    idle(); bus.pc_src = 3'd1; bus.imm16 = 16'hFFFE; bus.br_taken = 1'b1;
    tick(); check_val("br_taken", bus.pc, 32'h0000_00FC);
    jr_to(32'h0000_0100); tick();
    idle(); bus.pc_src = 3'd1; bus.imm16 = 16'hFFFE; bus.br_taken = 1'b0;
    tick(); check_val("br_not_taken", bus.pc, 32'h0000_0104);

    // Jump register in user and kernel mode
    jr_to(32'h0000_0040); tick();
    jr_to(32'h8000_1000); tick(); check_val("jr_user", bus.pc, 32'h0000_1000);
    idle(); bus.pc_src = 3'd5; tick(); check_val("xadr", bus.pc, 32'h8000_0008);
    jr_to(32'h8000_0040); tick();
    jr_to(32'h8000_1000); tick(); check_val("jr_kernel", bus.pc, 32'h8000_1000);
    idle(); bus.eret = 1'b1; tick(); check_val("eret_xadr", bus.pc, 32'h0000_1000);

    // Two channels rise together; lowest enabled index goes first
    jr_to(32'h0000_0200); bus.mask_we = 1'b1; bus.mask_wdata = 4'b1010; bus.irq = 4'b1010;
    tick();
    idle(); tick();
    check_val("irq1_take",  bus.irq_take,    32'd1);
    check_val("irq1_cause", bus.irq_cause,   32'd1);
    check_val("irq1_epc",   bus.epc,         32'h0000_0200);
    check_val("irq1_pc",    bus.pc,          VEC1);
    check_val("irq1_pend",  bus.irq_pending, 32'b1000);
    idle(); bus.eret = 1'b1; tick(); check_val("eret_irq1", bus.pc, 32'h0000_0200);
    idle(); tick();
    check_val("irq3_take",  bus.irq_take,  32'd1);
    check_val("irq3_cause", bus.irq_cause, 32'd3);
    check_val("irq3_pc",    bus.pc,        VEC3);
    idle(); bus.eret = 1'b1; tick();

    // Stall blocks entry; release enters on that edge
    idle(); bus.irq = 4'b0000; tick(); check_val("pre_stall", bus.pc, 32'h0000_0204);
    idle(); bus.irq = 4'b0010; bus.stall = 1'b1; tick();
    tick();
    check_val("stall_pc",   bus.pc,       32'h0000_0204);
    check_val("stall_take", bus.irq_take, 32'd0);
    idle(); tick();
    check_val("unstall_take", bus.irq_take, 32'd1);
    check_val("unstall_pc",   bus.pc,       VEC1);

    // Asynchronous reset in the middle of a handler
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_pc",    bus.pc,          32'h8000_0000);
    check_val("arst_insvc", bus.in_service,  32'd0);
    check_val("arst_pend",  bus.irq_pending, 32'd0);
    check_val("arst_epc",   bus.epc,         32'd0);
    m_reset();
    tick();
    reset = 1'b0;

    // Mask cleared by reset: pending request is not taken
    jr_to(32'h0000_0300); bus.irq = 4'b1111; tick();
    idle(); tick(); tick();
    check_val("mask0_no_take", bus.irq_take, 32'd0);

    // Random stimulus against the model
    for (int c = 0; c < 800; c++) begin
      idle();
      bus.stall = ($urandom_range(0, 99) < 15);
      r = $urandom_range(0, 99);
      if      (r < 40) bus.pc_src = 3'd0;
      else if (r < 60) bus.pc_src = 3'd1;
      else if (r < 70) bus.pc_src = 3'd2;
      else if (r < 84) bus.pc_src = 3'd3;
      else if (r < 88) bus.pc_src = 3'd4;
      else if (r < 91) bus.pc_src = 3'd5;
      else if (r < 93) bus.pc_src = 3'($urandom_range(6, 7));
      else             bus.pc_src = 3'd0;
      bus.br_taken = 1'($urandom);
      bus.imm16    = 16'($urandom);
      bus.target26 = 26'($urandom);
      bus.jr_addr  = $urandom;
      bus.eret     = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 10) begin
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'($urandom);
      end
      if ($urandom_range(0, 99) < 20) bus.irq = 4'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
